delay_arb: RTL and testbench

DELAY_ARB -- requirements
Module: delay_arb

---
 rtl/delay_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_delay_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_arb.sv
// Two-requester Avalon-ST packet arbiter feeding a delay line, plus a
// switch-driven flush sequencer that walks the delay line's full address range.
package delay_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               valid;
    } avln_st;

endpackage

// state  | meaning
// IDLE   | no owner; pick flush or a requester, discard stray non-sop beats
// GRANT0 | in0 owns the output until its eop beat is accepted
// GRANT1 | in1 owns the output until its eop beat is accepted
// FLUSH  | flush_ctl = 01 for 2**ADDR_W cycles, or until SW[1] aborts
module delay_arb
    import delay_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int FLUSH_W = ADDR_W + 1
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  avln_st      in0,
    input  avln_st      in1,
    output logic        rdy0,
    output logic        rdy1,
    input  logic [17:0] SW,
    output avln_st      out,
    output logic [1:0]  flush_ctl,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((64'd1 << ADDR_W) - 64'd1);

    state_t             state;
    state_t             state_nxt;
    logic               rr;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               sw1_q;

    logic flush_req;
    logic req0;
    logic req1;
    logic stray0;
    logic stray1;
    logic acc0;
    logic acc1;
    logic gacc0;
    logic gacc1;
    logic drop0;
    logic drop1;
    logic done0;
    logic done1;
    logic flush_end;

    logic [1:0]  drop_add;
    logic [16:0] drop_sum;
    logic        unused_sw;

    assign unused_sw = ^SW[17:2];

    assign flush_req = SW[0] & ~SW[1];
    assign req0      = in0.valid & in0.sop;
    assign req1      = in1.valid & in1.sop;
    assign stray0    = in0.valid & ~in0.sop;
    assign stray1    = in1.valid & ~in1.sop;

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        case (state)
            GRANT0:  rdy0 = 1'b1;
            GRANT1:  rdy1 = 1'b1;
            IDLE: begin
                rdy0 = stray0;
                rdy1 = stray1;
            end
            default: ;
        endcase
    end

    assign acc0  = in0.valid & rdy0;
    assign acc1  = in1.valid & rdy1;
    assign gacc0 = acc0 & (state == GRANT0);
    assign gacc1 = acc1 & (state == GRANT1);
    assign drop0 = acc0 & (state == IDLE);
    assign drop1 = acc1 & (state == IDLE);
    assign done0 = gacc0 & in0.eop;
    assign done1 = gacc1 & in1.eop;

    // SW[1] aborts a flush at once; otherwise it ends on the last address.
    assign flush_end = SW[1] | (flush_cnt == FLUSH_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else if (req0 && req1) begin
                    state_nxt = rr ? GRANT1 : GRANT0;
                end else if (req0) begin
                    state_nxt = GRANT0;
                end else if (req1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (done0) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (done1) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (flush_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr <= 1'b0;
        end else if (done0) begin
            rr <= 1'b1;
        end else if (done1) begin
            rr <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt <= '0;
        end else if ((state == FLUSH) && (state_nxt == FLUSH)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else begin
            flush_cnt <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sw1_q <= 1'b0;
        end else begin
            sw1_q <= SW[1];
        end
    end

    // data/empty hold between beats; only the qualifiers drop back to 0.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else if (gacc0) begin
            out <= in0;
        end else if (gacc1) begin
            out <= in1;
        end else begin
            out.valid <= 1'b0;
            out.sop   <= 1'b0;
            out.eop   <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (done0) begin
                pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
            if (done1) begin
                pkt_cnt1 <= pkt_cnt1 + 16'd1;
            end
        end
    end

    assign drop_add = {1'b0, drop0} + {1'b0, drop1};
    assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_add};

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign flush_ctl = {sw1_q, (state == FLUSH)};
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_delay_arb.sv
// Directed bench for delay_arb with a 16-entry delay line (ADDR_W = 4).
module tb_delay_arb;
    import delay_arb_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    avln_st      in0;
    avln_st      in1;
    avln_st      out_s;
    logic        rdy0;
    logic        rdy1;
    logic [17:0] sw;
    logic [1:0]  flush_ctl;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
    logic [15:0] drop_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    delay_arb #(.ADDR_W(4)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .in0       (in0),
        .in1       (in1),
        .rdy0      (rdy0),
        .rdy1      (rdy1),
        .SW        (sw),
        .out       (out_s),
        .flush_ctl (flush_ctl),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic avln_st mk(input logic [31:0] d, input logic s, input logic e, input logic v);
        avln_st b;
        b       = '0;
        b.data  = d;
        b.sop   = s;
        b.eop   = e;
        b.empty = d[1:0];
        b.valid = v;
        return b;
    endfunction

    // 4-beat packet on in0 with no contention; each beat must appear one cycle late.
    task automatic send_pkt0(input logic [31:0] base, input string tag);
        in0 = mk(base, 1'b1, 1'b0, 1'b1);
        #1;
        chk({tag, "_rdy_idle"}, rdy0, 0);
        step();
        chk({tag, "_rdy_grant"}, rdy0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk({tag, "_valid"}, out_s.valid, 1);
            chk({tag, "_data"}, out_s.data, base + 32'(i));
            chk({tag, "_sop"}, out_s.sop, (i == 0));
            chk({tag, "_eop"}, out_s.eop, (i == 3));
            chk({tag, "_empty"}, out_s.empty, 2'((base + 32'(i)) & 32'h3));
            if (i < 3) begin
                in0 = mk(base + 32'(i) + 32'd1, 1'b0, (i == 2), 1'b1);
            end else begin
                in0 = '0;
            end
        end
        chk({tag, "_idle_after"}, busy, 0);
        step();
        chk({tag, "_valid_off"}, out_s.valid, 0);
        chk({tag, "_data_hold"}, out_s.data, base + 32'd3);
    endtask

    // Samples one flush run starting in its first FLUSH cycle; stops on the first non-flush sample.
    task automatic count_flush(output int n, output int viol);
        n    = 0;
        viol = 0;
        for (int k = 0; k < 40; k++) begin
            if (flush_ctl != 2'b01) begin
                break;
            end
            n++;
            if (rdy0 || rdy1) begin
                viol++;
            end
            step();
        end
    endtask

    int   p0, b0, p1, b1;
    logic a0, a1;
    int   order[$];
    int   eop_cyc;
    int   sop_cyc;
    int   fl_n;
    int   fl_viol;

    initial begin
        in0     = '0;
        in1     = '0;
        sw      = '0;
        reset_n = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_out", out_s, 0);
        chk("rst_flush", flush_ctl, 0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_rdy0", rdy0, 0);
        reset_n = 1'b1;
        step();

        send_pkt0(32'hA0, "s1");
        chk("s1_cnt0", pkt_cnt0, 1);

        // round robin from a fresh reset: both request together twice
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        p0 = 0; b0 = 0; p1 = 0; b1 = 0;
        eop_cyc = -1;
        sop_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (p0 < 2) in0 = mk(32'h1000 | 32'(p0 << 4) | 32'(b0), (b0 == 0), (b0 == 1), 1'b1);
            else        in0 = '0;
            if (p1 < 2) in1 = mk(32'h1100 | 32'(p1 << 4) | 32'(b1), (b1 == 0), (b1 == 1), 1'b1);
            else        in1 = '0;
            #1;
            a0 = in0.valid & rdy0;
            a1 = in1.valid & rdy1;
            step();
            if (a0) begin
                b0++;
                if (b0 == 2) begin b0 = 0; p0++; end
            end
            if (a1) begin
                b1++;
                if (b1 == 2) begin b1 = 0; p1++; end
            end
            if (out_s.valid && out_s.sop) begin
                order.push_back(int'(out_s.data[8]));
                if (order.size() == 2) sop_cyc = c;
            end
            if (out_s.valid && out_s.eop && eop_cyc < 0) eop_cyc = c;
        end
        chk("rr_count", order.size(), 4);
        chk("rr_order0", (order.size() > 0) ? order[0] : 9, 0);
        chk("rr_order1", (order.size() > 1) ? order[1] : 9, 1);
        chk("rr_order2", (order.size() > 2) ? order[2] : 9, 0);
        chk("rr_order3", (order.size() > 3) ? order[3] : 9, 1);
        chk("rr_gap", sop_cyc - eop_cyc, 2);
        chk("rr_cnt0", pkt_cnt0, 2);
        chk("rr_cnt1", pkt_cnt1, 2);

        // stray non-sop beats in IDLE are swallowed
        for (int i = 0; i < 3; i++) begin
            in1 = mk(32'h2000 + 32'(i), 1'b0, 1'b0, 1'b1);
            #1;
            chk("drop_rdy1", rdy1, 1);
            chk("drop_rdy0", rdy0, 0);
            step();
            chk("drop_valid", out_s.valid, 0);
            chk("drop_busy", busy, 0);
        end
        in1 = '0;
        chk("drop_cnt", drop_cnt, 3);
        chk("drop_hold", out_s.data, 32'h1111);

        // flush requested mid-packet waits for eop, then beats contending requesters
        in0 = mk(32'h30, 1'b1, 1'b0, 1'b1);
        step();
        step();
        in0   = mk(32'h31, 1'b0, 1'b0, 1'b1);
        sw[0] = 1'b1;
        step();
        chk("fl_midpkt_busy", busy, 1);
        chk("fl_midpkt_ctl", flush_ctl, 0);
        in0 = mk(32'h32, 1'b0, 1'b1, 1'b1);
        step();
        chk("fl_pkt_cnt0", pkt_cnt0, 3);
        chk("fl_pkt_last", out_s.data, 32'h32);
        in0 = mk(32'h40, 1'b1, 1'b0, 1'b1);
        in1 = mk(32'h50, 1'b1, 1'b0, 1'b1);
        step();
        sw[0] = 1'b0;
        count_flush(fl_n, fl_viol);
        in0 = '0;
        in1 = '0;
        chk("fl_len", fl_n, 16);
        chk("fl_rdy_low", fl_viol, 0);
        chk("fl_exit_idle", busy, 0);
        chk("fl_out_idle", out_s.valid, 0);
        step();

        // abort at flush count 5
        sw[0] = 1'b1;
        step();
        sw[0] = 1'b0;
        chk("ab_enter", flush_ctl, 2'b01);
        repeat (5) step();
        chk("ab_still", busy, 1);
        sw[1] = 1'b1;
        step();
        chk("ab_idle", busy, 0);
        chk("ab_ctl", flush_ctl, 2'b10);
        sw[1] = 1'b0;
        step();
        chk("ab_ctl_clr", flush_ctl, 2'b00);
        sw[0] = 1'b1;
        step();
        sw[0] = 1'b0;
        count_flush(fl_n, fl_viol);
        chk("ab_reflush_len", fl_n, 16);

        // reset during beat 2 of a 4-beat packet
        in0 = mk(32'h60, 1'b1, 1'b0, 1'b1);
        step();
        step();
        in0 = mk(32'h61, 1'b0, 1'b0, 1'b1);
        step();
        in0 = mk(32'h62, 1'b0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        in0     = '0;
        #1;
        chk("mr_out", out_s, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cnt0", pkt_cnt0, 0);
        chk("mr_cnt1", pkt_cnt1, 0);
        chk("mr_drop", drop_cnt, 0);
        chk("mr_flush", flush_ctl, 0);
        chk("mr_rdy0", rdy0, 0);
        chk("mr_rdy1", rdy1, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("mr_no_partial", out_s.valid, 0);
        send_pkt0(32'h70, "mr");
        chk("mr_cnt0_after", pkt_cnt0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
